// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one registered ALU between N_REQ requesters,
// holding operands for the ALU latency and returning the result over valid/ready.
module alu_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [3*N_REQ-1:0]      req_funct3,
  input  logic [7*N_REQ-1:0]      req_funct7,
  input  logic [N_REQ-1:0]        req_alu_sel,
  input  logic [XLEN*N_REQ-1:0]   req_x,
  input  logic [XLEN*N_REQ-1:0]   req_y,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [XLEN-1:0]         rsp_data,
  output logic                    rsp_err,
  output logic [2:0]              alu_funct3,
  output logic [6:0]              alu_funct7,
  output logic                    alu_sel,
  output logic [XLEN-1:0]         alu_x,
  output logic [XLEN-1:0]         alu_y,
  input  logic [XLEN-1:0]         alu_out,
  output logic                    busy
);

  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
  logic [ID_W-1:0]   owner, owner_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [N_REQ-1:0]  rsp_valid_d;
  logic [XLEN-1:0]   rsp_data_d;
  logic              rsp_err_d;
  logic [2:0]        alu_funct3_d;
  logic [6:0]        alu_funct7_d;
  logic              alu_sel_d;
  logic [XLEN-1:0]   alu_x_d, alu_y_d;
  logic              busy_d;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   win_next;
  logic [2:0]        win_f3;
  logic [6:0]        win_f7;
  logic              win_sel;
  logic [XLEN-1:0]   win_x, win_y;

  // Op encodings the attached ALU implements.
  function automatic logic op_supported(input logic [2:0] f3, input logic [6:0] f7,
                                        input logic sel);
    if (sel)
      op_supported = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
                     (f3 == 3'b110) || (f3 == 3'b111);
    else if (f3 == 3'b000)
      op_supported = (f7 == 7'b0000000) || (f7 == 7'b0100000);
    else
      op_supported = (f3 != 3'b101);
  endfunction

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin : win_scan
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    win_next = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
    win_f3   = req_funct3[int'(win_id)*3 +: 3];
    win_f7   = req_funct7[int'(win_id)*7 +: 7];
    win_sel  = req_alu_sel[win_id];
    win_x    = req_x[int'(win_id)*int'(XLEN) +: XLEN];
    win_y    = req_y[int'(win_id)*int'(XLEN) +: XLEN];
  end

  // Grant is combinational so the winner sees ready in the same cycle it is chosen.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_found) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    state_d      = state;
    rr_ptr_d     = rr_ptr;
    owner_d      = owner;
    cnt_d        = cnt;
    rsp_valid_d  = rsp_valid;
    rsp_data_d   = rsp_data;
    rsp_err_d    = rsp_err;
    alu_funct3_d = alu_funct3;
    alu_funct7_d = alu_funct7;
    alu_sel_d    = alu_sel;
    alu_x_d      = alu_x;
    alu_y_d      = alu_y;

    unique case (state)
      IDLE: begin
        if (win_found) begin
          owner_d  = win_id;
          rr_ptr_d = win_next;
          if (op_supported(win_f3, win_f7, win_sel)) begin
            alu_funct3_d = win_f3;
            alu_funct7_d = win_f7;
            alu_sel_d    = win_sel;
            alu_x_d      = win_x;
            alu_y_d      = win_y;
            cnt_d        = CNT_W'(ALU_LAT);
            state_d      = EXEC;
          end else begin
            rsp_data_d           = '0;
            rsp_err_d            = 1'b1;
            rsp_valid_d          = '0;
            rsp_valid_d[win_id]  = 1'b1;
            state_d              = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          rsp_data_d          = alu_out;
          rsp_err_d           = 1'b0;
          rsp_valid_d         = '0;
          rsp_valid_d[owner]  = 1'b1;
          state_d             = RESP;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready[owner]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      cnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      alu_funct3 <= '0;
      alu_funct7 <= '0;
      alu_sel    <= 1'b0;
      alu_x      <= '0;
      alu_y      <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      owner      <= owner_d;
      cnt        <= cnt_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_err    <= rsp_err_d;
      alu_funct3 <= alu_funct3_d;
      alu_funct7 <= alu_funct7_d;
      alu_sel    <= alu_sel_d;
      alu_x      <= alu_x_d;
      alu_y      <= alu_y_d;
      busy       <= busy_d;
    end
  end

endmodule
